encoder_distance_counter: RTL and testbench

- Upstream stage feeding the Nios system's encoderincm/encoderreset PIO pair.
- Conditions raw quadrature wheel-encoder channels: synchronizer, glitch filter, quadrature decode.
- Converts encoder ticks into a signed distance in whole centimetres.
- Provides direction and an illegal-transition error flag; distance clears under software control.

---
 rtl/encoder_distance_counter.sv | 203 ++++++++++++++++++++
 tb/tb_encoder_distance_counter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_distance_counter.sv
// ---------------------------------------------------------------------------
// encoder_distance_counter
//
// Conditions a raw quadrature wheel encoder (synchronizer, glitch filter,
// quadrature decode) and accumulates the decoded ticks into a signed
// distance in whole centimetres for the Nios encoderincm PIO. The
// encoderreset PIO level clears the distance and the sticky error flag.
//
// Pipeline from a clean input edge to the distance output:
//   SYNC_STAGES  synchronizer flops
//   GLITCH_CYCLES  stable cycles before the filtered value follows
//   1 cycle   decoded tick lands in the cm/sub accumulator
//   1 cycle   output register
// ---------------------------------------------------------------------------
module encoder_distance_counter #(
  parameter int TICKS_PER_CM  = 20,
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 4,
  parameter int CM_WIDTH      = 32
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                enc_a,
  input  logic                enc_b,
  input  logic                encoder_reset,
  output logic [CM_WIDTH-1:0] encoderincm,
  output logic                enc_dir,
  output logic                enc_error
);

  // -------------------------------------------------------------------------
  // Derived sizes and constants
  // -------------------------------------------------------------------------
  localparam int SUB_W  = (TICKS_PER_CM > 2) ? $clog2(TICKS_PER_CM) : 1;
  localparam int GCNT_W = $clog2(GLITCH_CYCLES + 1);

  // Last sub-centimetre position before rolling into the next centimetre.
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_CM - 1);

  // Filter counter value on which the next differing cycle commits.
  localparam logic [GCNT_W-1:0] GLITCH_LAST = GCNT_W'(GLITCH_CYCLES - 1);

  // Two's-complement saturation limits of the distance register.
  localparam logic [CM_WIDTH-1:0] CM_POS_MAX = {1'b0, {(CM_WIDTH-1){1'b1}}};
  localparam logic [CM_WIDTH-1:0] CM_NEG_MAX = {1'b1, {(CM_WIDTH-1){1'b0}}};

  // -------------------------------------------------------------------------
  // Channel conditioning: bit 1 = A, bit 0 = B throughout
  // -------------------------------------------------------------------------
  logic [1:0] w_raw;
  logic [1:0] w_sync;
  logic [1:0] w_filt;

  assign w_raw = {enc_a, enc_b};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] r_sync;
    logic [GCNT_W-1:0]      r_gcnt;
    logic                   r_filt;

    // Synchronizer shift chain bringing the asynchronous channel into clk_clk.
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[ch]};
      end
    end

    assign w_sync[ch] = r_sync[SYNC_STAGES-1];

    // Glitch filter: follow the synchronized level only after it has
    // differed from the filtered level for GLITCH_CYCLES consecutive cycles.
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        r_gcnt <= '0;
        r_filt <= 1'b0;
      end else if (w_sync[ch] == r_filt) begin
        r_gcnt <= '0;
      end else if (r_gcnt == GLITCH_LAST) begin
        r_filt <= w_sync[ch];
        r_gcnt <= '0;
      end else begin
        r_gcnt <= r_gcnt + 1'b1;
      end
    end

    assign w_filt[ch] = r_filt;
  end

  // -------------------------------------------------------------------------
  // Decoder and accumulator state
  // -------------------------------------------------------------------------
  logic [1:0]          r_prev;
  logic [CM_WIDTH-1:0] r_cm;
  logic [SUB_W-1:0]    r_sub;
  logic                r_dir;
  logic                r_err;

  logic                w_tick_fwd;
  logic                w_tick_rev;
  logic                w_tick_bad;
  logic [CM_WIDTH-1:0] w_cm_nxt;
  logic [SUB_W-1:0]    w_sub_nxt;

  // Quadrature decode of previous vs current filtered {A,B}.
  always_comb begin
    w_tick_fwd = 1'b0;
    w_tick_rev = 1'b0;
    w_tick_bad = 1'b0;
    case ({r_prev, w_filt})
      // forward 00 -> 01 -> 11 -> 10 -> 00
      4'b0001, 4'b0111, 4'b1110, 4'b1000: w_tick_fwd = 1'b1;
      // reverse 00 -> 10 -> 11 -> 01 -> 00
      4'b0010, 4'b1011, 4'b1101, 4'b0100: w_tick_rev = 1'b1;
      // both channels moved at once: position is ambiguous
      4'b0011, 4'b1100, 4'b0110, 4'b1001: w_tick_bad = 1'b1;
      // unchanged state
      default: w_tick_fwd = 1'b0;
    endcase
  end

  // Next cm/sub for the decoded tick, holding at either saturation limit.
  always_comb begin
    w_cm_nxt  = r_cm;
    w_sub_nxt = r_sub;
    if (w_tick_fwd) begin
      if (r_sub == SUB_LAST) begin
        if (r_cm != CM_POS_MAX) begin
          w_sub_nxt = '0;
          w_cm_nxt  = r_cm + 1'b1;
        end else begin
          w_sub_nxt = r_sub;
          w_cm_nxt  = r_cm;
        end
      end else begin
        w_sub_nxt = r_sub + 1'b1;
      end
    end else if (w_tick_rev) begin
      if (r_sub == '0) begin
        if (r_cm != CM_NEG_MAX) begin
          w_sub_nxt = SUB_LAST;
          w_cm_nxt  = r_cm - 1'b1;
        end else begin
          w_sub_nxt = r_sub;
          w_cm_nxt  = r_cm;
        end
      end else begin
        w_sub_nxt = r_sub - 1'b1;
      end
    end else begin
      w_cm_nxt  = r_cm;
      w_sub_nxt = r_sub;
    end
  end

  // Decoder history and direction keep tracking even while the count is
  // held clear, so releasing encoder_reset never produces a phantom tick.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_prev <= 2'b00;
      r_dir  <= 1'b0;
    end else begin
      r_prev <= w_filt;
      if (w_tick_fwd || w_tick_rev) begin
        r_dir <= w_tick_rev;
      end
    end
  end

  // Distance accumulator and sticky error; encoder_reset overrides any tick.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_cm  <= '0;
      r_sub <= '0;
      r_err <= 1'b0;
    end else if (encoder_reset) begin
      r_cm  <= '0;
      r_sub <= '0;
      r_err <= 1'b0;
    end else begin
      r_cm  <= w_cm_nxt;
      r_sub <= w_sub_nxt;
      if (w_tick_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  // Output register stage: no combinational path from any input to a port.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      encoderincm <= '0;
      enc_dir     <= 1'b0;
      enc_error   <= 1'b0;
    end else begin
      encoderincm <= r_cm;
      enc_dir     <= r_dir;
      enc_error   <= r_err;
    end
  end

endmodule

// File: tb/tb_encoder_distance_counter.sv
// ---------------------------------------------------------------------------
// Bench for encoder_distance_counter.
// Two instances share the encoder stimulus: a 32-bit one and a 4-bit one
// whose small range makes both saturation limits reachable by real ticks.
// The model tracks total tick position per instance and derives the
// centimetre value by floor division; outputs are compared every cycle.
// ---------------------------------------------------------------------------
module tb_encoder_distance_counter;

  localparam int TPC  = 4;
  localparam int SYNC = 2;
  localparam int GLT  = 4;
  localparam int LAT  = SYNC + GLT + 2;   // edges from first sample to output
  localparam int HOLD = 10;               // cycles each level is held

  // Tick-position limits: cm in [-2^(W-1), 2^(W-1)-1], sub in [0, TPC-1]
  localparam longint HI_M = 64'sd8589934591;
  localparam longint LO_M = -64'sd8589934592;
  localparam longint HI_S = 64'sd31;
  localparam longint LO_S = -64'sd32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        enc_rst = 1'b0;
  logic [31:0] cm_main;
  logic        dir_main;
  logic        err_main;
  logic [3:0]  cm_sat;
  logic        dir_sat;
  logic        err_sat;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state
  longint     pos_m = 0;
  longint     pos_s = 0;
  logic       dir_m = 1'b0;
  logic       err_m = 1'b0;
  logic [1:0] st_m  = 2'b00;

  encoder_distance_counter #(
    .TICKS_PER_CM(TPC), .SYNC_STAGES(SYNC), .GLITCH_CYCLES(GLT), .CM_WIDTH(32)
  ) u_dut (
    .clk_clk(clk), .reset_reset(rst), .enc_a(enc_a), .enc_b(enc_b),
    .encoder_reset(enc_rst), .encoderincm(cm_main), .enc_dir(dir_main),
    .enc_error(err_main)
  );

  encoder_distance_counter #(
    .TICKS_PER_CM(TPC), .SYNC_STAGES(SYNC), .GLITCH_CYCLES(GLT), .CM_WIDTH(4)
  ) u_sat (
    .clk_clk(clk), .reset_reset(rst), .enc_a(enc_a), .enc_b(enc_b),
    .encoder_reset(enc_rst), .encoderincm(cm_sat), .enc_dir(dir_sat),
    .enc_error(err_sat)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] sx4(input logic [3:0] v);
    return {{60{v[3]}}, v};
  endfunction

  function automatic longint floor_div(input longint p);
    if (p >= 0) return p / TPC;
    return -((-p + TPC - 1) / TPC);
  endfunction

  function automatic longint clampl(input longint p, input longint lo, input longint hi);
    if (p > hi) return hi;
    if (p < lo) return lo;
    return p;
  endfunction

  // position of a state along the forward Gray cycle 00,01,11,10
  function automatic int gidx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gcode(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    return gcode(gidx(s) + 1);
  endfunction

  function automatic logic [1:0] rev_of(input logic [1:0] s);
    return gcode(gidx(s) + 3);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model reaction to the filtered encoder moving from st_m to nxt
  task automatic model_move(input logic [1:0] nxt);
    int d;
    d = (gidx(nxt) - gidx(st_m) + 4) % 4;
    if (d == 1) begin
      pos_m = clampl(pos_m + 1, LO_M, HI_M);
      pos_s = clampl(pos_s + 1, LO_S, HI_S);
      dir_m = 1'b0;
    end else if (d == 3) begin
      pos_m = clampl(pos_m - 1, LO_M, HI_M);
      pos_s = clampl(pos_s - 1, LO_S, HI_S);
      dir_m = 1'b1;
    end else if (d == 2) begin
      err_m = 1'b1;
    end
    st_m = nxt;
  endtask

  task automatic step(input logic [1:0] nxt);
    @(negedge clk);
    {enc_a, enc_b} = nxt;
    repeat (LAT) @(posedge clk);
    model_move(nxt);
    repeat (HOLD - LAT) @(posedge clk);
  endtask

  task automatic fwd_n(input int n);
    for (int i = 0; i < n; i++) step(fwd_of(st_m));
  endtask

  task automatic rev_n(input int n);
    for (int i = 0; i < n; i++) step(rev_of(st_m));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    enc_a = 1'b0;
    enc_b = 1'b0;
    @(posedge clk);
    pos_m = 0; pos_s = 0; dir_m = 1'b0; err_m = 1'b0; st_m = 2'b00;
    #1;
    chk("rst_cm",  sx32(cm_main), 64'd0);
    chk("rst_dir", {63'd0, dir_main}, 64'd0);
    chk("rst_err", {63'd0, err_main}, 64'd0);
    repeat (cycles - 1) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_enc_rst();
    @(negedge clk);
    enc_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enc_rst = 1'b0;
    @(posedge clk);
    pos_m = 0; pos_s = 0; err_m = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // every-cycle comparison of both instances against the model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("cm_main",  sx32(cm_main), floor_div(pos_m));
      chk("cm_sat",   sx4(cm_sat),   floor_div(pos_s));
      chk("dir_main", {63'd0, dir_main}, {63'd0, dir_m});
      chk("dir_sat",  {63'd0, dir_sat},  {63'd0, dir_m});
      chk("err_main", {63'd0, err_main}, {63'd0, err_m});
      chk("err_sat",  {63'd0, err_sat},  {63'd0, err_m});
    end
  end

  initial begin
    #500000;
    total++;
    bad++;
    $display("FAIL watchdog: run exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // power-on reset
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1;
    chk("init_cm",  sx32(cm_main), 64'd0);
    chk("init_dir", {63'd0, dir_main}, 64'd0);
    chk("init_err", {63'd0, err_main}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // forward rotation: 12 ticks, first cm increment probed at the bound
    for (int i = 0; i < 12; i++) begin
      if (i == 3) begin
        @(negedge clk);
        {enc_a, enc_b} = fwd_of(st_m);
        repeat (LAT - 1) @(posedge clk);
        #1;
        chk("lat_before", sx32(cm_main), 64'd0);
        @(posedge clk);
        model_move(fwd_of(st_m));
        #1;
        chk("lat_at_bound", sx32(cm_main), 64'd1);
        repeat (HOLD - LAT) @(posedge clk);
      end else begin
        step(fwd_of(st_m));
      end
    end
    chk("fwd_cm",  sx32(cm_main), 64'd3);
    chk("fwd_dir", {63'd0, dir_main}, 64'd0);
    chk("fwd_err", {63'd0, err_main}, 64'd0);

    // reverse through zero
    do_reset(2);
    step(rev_of(st_m));
    chk("rz_cm",  {32'd0, cm_main}, {32'd0, 32'hFFFF_FFFF});
    chk("rz_dir", {63'd0, dir_main}, 64'd1);
    chk("rz_sat", {60'd0, cm_sat}, {60'd0, 4'hF});
    step(fwd_of(st_m));
    chk("rz_back_cm",  sx32(cm_main), 64'd0);
    chk("rz_back_dir", {63'd0, dir_main}, 64'd0);

    // glitch rejection: 3-cycle pulse on A is dropped
    @(negedge clk);
    enc_a = 1'b1;
    repeat (3) @(negedge clk);
    enc_a = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("glitch_cm",  sx32(cm_main), 64'd0);
    chk("glitch_dir", {63'd0, dir_main}, 64'd0);
    // 4-cycle pulse on B passes: one forward tick, then one reverse tick
    @(negedge clk);
    enc_b = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    enc_b = 1'b0;
    repeat (4) @(posedge clk);
    model_move(2'b01);
    repeat (4) @(posedge clk);
    model_move(2'b00);
    repeat (6) @(posedge clk);
    #1;
    chk("pulse4_dir", {63'd0, dir_main}, 64'd1);
    chk("pulse4_cm",  sx32(cm_main), 64'd0);

    // illegal 00 -> 11 jump
    step(2'b11);
    chk("ill_err", {63'd0, err_main}, 64'd1);
    chk("ill_cm",  sx32(cm_main), 64'd0);
    chk("ill_dir", {63'd0, dir_main}, 64'd1);
    fwd_n(8);
    chk("ill_sticky_err", {63'd0, err_main}, 64'd1);
    chk("ill_sticky_cm",  sx32(cm_main), 64'd2);
    pulse_enc_rst();
    chk("clr_err", {63'd0, err_main}, 64'd0);
    chk("clr_cm",  sx32(cm_main), 64'd0);

    // encoder_reset coinciding with a decoded tick
    fwd_n(20);
    chk("prio_pre_cm", sx32(cm_main), 64'd5);
    @(negedge clk);
    {enc_a, enc_b} = fwd_of(st_m);
    repeat (LAT - 2) @(posedge clk);
    @(negedge clk);
    enc_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enc_rst = 1'b0;
    @(posedge clk);
    st_m = fwd_of(st_m); pos_m = 0; pos_s = 0; err_m = 1'b0; dir_m = 1'b0;
    repeat (HOLD - LAT) @(posedge clk);
    #1;
    chk("prio_cm", sx32(cm_main), 64'd0);
    fwd_n(4);
    chk("prio_post_cm", sx32(cm_main), 64'd1);

    // saturation on the 4-bit instance
    fwd_n(27);
    chk("satp_cm4", {60'd0, cm_sat}, {60'd0, 4'h7});
    chk("satp_cm",  sx32(cm_main), 64'd7);
    fwd_n(1);
    chk("satp_hold_cm4", {60'd0, cm_sat}, {60'd0, 4'h7});
    chk("satp_main_cm",  sx32(cm_main), 64'd8);
    rev_n(63);
    chk("satn_cm4", {60'd0, cm_sat}, {60'd0, 4'h8});
    rev_n(2);
    chk("satn_hold_cm4", {60'd0, cm_sat}, {60'd0, 4'h8});
    chk("satn_dir4", {63'd0, dir_sat}, 64'd1);
    chk("satn_main_cm", {32'd0, cm_main}, {32'd0, 32'hFFFF_FFF7});
    fwd_n(1);
    chk("satn_back_cm4", {60'd0, cm_sat}, {60'd0, 4'h8});
    chk("satn_back_cm",  {32'd0, cm_main}, {32'd0, 32'hFFFF_FFF8});

    // reset_reset while a transition is still in the filter
    @(negedge clk);
    {enc_a, enc_b} = fwd_of(st_m);
    repeat (3) @(posedge clk);
    do_reset(2);
    repeat (12) @(posedge clk);
    fwd_n(3);
    chk("post_rst_cm", sx32(cm_main), 64'd0);
    fwd_n(1);
    chk("post_rst_cm1", sx32(cm_main), 64'd1);

    chk_en = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
